// File: rtl/comm_master.sv
// UART command master: sends a 3-byte command packet (cmd, data[15:8], data[7:0])
// on TX and captures single response bytes arriving on RX.
module comm_master #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_cmplt,
  output logic        busy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int            CW      = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] BaudMax = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HalfMax = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StHigh, StLow} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // ---------------------------------------------------------------- transmit
  tx_state_e     r_tx_state;
  logic [23:0]   r_hold;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic          r_tx;
  logic          r_busy;
  logic          r_cmplt;
  logic [7:0]    w_tx_byte;
  logic          w_accept;
  logic          w_bit_end;

  assign w_accept  = (r_tx_state == StIdle) && snd_cmd;
  assign w_bit_end = (r_tx_cnt == BaudMax);

  always_comb begin
    case (r_tx_state)
      StHigh:  w_tx_byte = r_hold[15:8];
      StLow:   w_tx_byte = r_hold[7:0];
      default: w_tx_byte = r_hold[23:16];
    endcase
  end

  // r_tx_bit names the bit currently on the line: 0 start, 1..8 data, 9 stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= StIdle;
      r_hold     <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_cmplt    <= 1'b0;
    end else begin
      case (r_tx_state)
        StIdle: begin
          if (snd_cmd) begin
            r_hold     <= {cmd, data};
            r_cmplt    <= 1'b0;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= StCmd;
          end
        end
        default: begin
          if (!w_bit_end) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end else begin
            r_tx_cnt <= '0;
            if (r_tx_bit != 4'd9) begin
              r_tx_bit <= r_tx_bit + 1'b1;
              r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : w_tx_byte[r_tx_bit[2:0]];
            end else begin
              r_tx_bit <= '0;
              if (r_tx_state == StLow) begin
                r_tx_state <= StIdle;
                r_tx       <= 1'b1;
                r_busy     <= 1'b0;
                r_cmplt    <= 1'b1;
              end else begin
                // Next start bit immediately, no idle gap between frames.
                r_tx       <= 1'b0;
                r_tx_state <= (r_tx_state == StCmd) ? StHigh : StLow;
              end
            end
          end
        end
      endcase
    end
  end

  assign TX        = r_tx;
  assign busy      = r_busy;
  assign cmd_cmplt = r_cmplt;

  // ----------------------------------------------------------------- receive
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  rx_state_e     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_resp;
  logic          r_resp_rdy;
  logic          w_rx_fall;
  logic          w_rx_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_load = (r_rx_state == RxStop) && (r_rx_cnt == BaudMax) && r_rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_resp     <= 8'h00;
      r_resp_rdy <= 1'b0;
    end else begin
      case (r_rx_state)
        RxIdle: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (r_rx_cnt == HalfMax) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_sync ? RxIdle : RxData;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RxData: begin
          if (r_rx_cnt == BaudMax) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_state <= RxStop;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (r_rx_cnt == BaudMax) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RxIdle;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase

      // A response landing on the same edge as a clear wins.
      if (w_rx_load) begin
        r_resp     <= r_rx_shift;
        r_resp_rdy <= 1'b1;
      end else if (clr_resp_rdy || w_accept) begin
        r_resp_rdy <= 1'b0;
      end
    end
  end

  assign resp     = r_resp;
  assign resp_rdy = r_resp_rdy;

endmodule
